lsu_ctrl: RTL and testbench

- Load/store controller sitting directly upstream of datamem.
- Takes one memory request at a time from the processor datapath: ALU-computed byte address, size, signedness, store data.
- Drives datamem's word-addressed port (we/address/writedata) and returns aligned, extended load data.
- Sub-word stores are performed as a read-modify-write, because datamem has no byte enables.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_lane.sv | 61 ++++++
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types for the load/store controller: access-size
//                encoding, controller state encoding, data width and an
//                alignment helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam int DATA_W = 32;

    // Request size encoding as presented on req_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_t;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_t;

    // True when the byte address is not naturally aligned for the size.
    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] lo);
        logic r;
        r = 1'b0;
        if (sz == SZ_HALF && lo[0])        r = 1'b1;
        if (sz == SZ_WORD && lo != 2'b00)  r = 1'b1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane
//  Description : Combinational byte-lane logic. Extracts and sign/zero
//                extends a byte or halfword from a memory word for loads, and
//                merges right-justified store data into a memory word for
//                sub-word stores.
//  Ports       : i_word     memory word (read data)
//                i_wdata    right-justified store data
//                i_offset   byte offset within the word (addr[1:0])
//                i_size     access size
//                i_unsigned 1 = zero-extend loads, 0 = sign-extend
//                o_load     extracted, extended load value
//                o_merge    i_word with the selected lane replaced
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_offset,
    input  lsu_size_t         i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merge
);

    logic [4:0]        w_shamt;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_ins;

    always_comb begin
        // Halfwords live at bit 0 or 16 only, so offset bit 0 is ignored.
        w_shamt = (i_size == SZ_HALF) ? {i_offset[1], 4'b0000} : {i_offset, 3'b000};
        w_shifted = i_word >> w_shamt;
        w_ins     = i_wdata << w_shamt;

        o_load = i_word;
        w_mask = '1;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
                w_mask = 32'h0000_00FF << w_shamt;
            end
            SZ_HALF: begin
                o_load = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
                w_mask = 32'h0000_FFFF << w_shamt;
            end
            default: begin
                o_load = i_word;
                w_mask = '1;
            end
        endcase

        o_merge = (i_word & ~w_mask) | (w_ins & w_mask);
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store controller in front of a word-addressed data
//                memory without byte enables. Accepts one request at a time,
//                performs loads, word stores and read-modify-write sub-word
//                stores, and returns aligned, extended load data.
//  Config      : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//                accesses return resp_err without touching memory; when
//                undefined, low address bits are forced to alignment.
//  Ports       : clk/reset             clock, synchronous active-high reset
//                req_*                 request handshake and payload
//                resp_*                one-cycle response with data/error
//                mem_*                 datamem port (combinational read)
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter int MEM_WORDS = 128,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import lsu_pkg::*;

    localparam int IDX_W = $clog2(MEM_WORDS);

    lsu_state_t        r_state;
    lsu_size_t         r_size;
    logic              r_unsigned;
    logic [1:0]        r_offset;
    logic [DATA_W-1:0] r_wdata;

    lsu_size_t         w_size;
    logic [31:0]       w_addr;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx;
    logic              w_accept;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;
    logic              w_unused;

    assign w_size    = lsu_size_t'(req_size);
    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_addr = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        w_err = (w_size == SZ_RSVD) || is_misaligned(w_size, req_addr[1:0]);
`else
        // Without the trap, misaligned accesses silently round down.
        if (w_size == SZ_HALF) w_addr[0]   = 1'b0;
        if (w_size == SZ_WORD) w_addr[1:0] = 2'b00;
        w_err = (w_size == SZ_RSVD);
`endif
    end

    // Addresses beyond the memory depth wrap: the upper bits are dropped.
    assign w_idx    = w_addr[IDX_W+1:2];
    assign w_unused = ^w_addr[31:IDX_W+2];

    lsu_lane u_lane (
        .i_word     (mem_rdata),
        .i_wdata    (r_wdata),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_offset   <= 2'b00;
            r_wdata    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    mem_we     <= 1'b0;
                    if (w_accept) begin
                        r_size     <= w_size;
                        r_unsigned <= req_unsigned;
                        r_offset   <= w_addr[1:0];
                        r_wdata    <= req_wdata;
                        resp_rdata <= '0;
                        mem_addr   <= {{(32-IDX_W){1'b0}}, w_idx};
                        if (w_err) begin
                            // Errors go straight to the response, memory untouched.
                            r_state    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (!req_write) begin
                            r_state <= ST_LOAD;
                        end else if (w_size == SZ_WORD) begin
                            r_state   <= ST_WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                        end else begin
                            r_state <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    resp_rdata <= w_load;
                    resp_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_WRITE: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RMW_RD: begin
                    // Merge is computed from the word read this cycle and
                    // written back next cycle.
                    mem_wdata <= w_merge;
                    mem_we    <= 1'b1;
                    r_state   <= ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    mem_addr   <= '0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Self-checking bench for lsu_ctrl. Provides a datamem model
//                and compares every response against a reference memory
//                updated from the byte-addressed access rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

    localparam int MEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_ctrl #(.MEM_WORDS(MEM_WORDS), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] dmem    [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    assign mem_rdata = dmem[mem_addr % MEM_WORDS];

    int          cyc = 0;
    int          we_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    int          acc_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            dmem[mem_addr % MEM_WORDS] <= mem_wdata;
            we_cnt  <= we_cnt + 1;
            we_addr <= mem_addr;
            we_data <= mem_wdata;
        end
        if (req_valid && req_ready) acc_cyc.push_back(cyc);
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!req_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // One request: reference result from the byte-address rules, then drive
    // and compare mem_addr, latency, response and any memory write.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
        logic        err;
        logic [31:0] aa, w, v, expd, mask, merged;
        int          idx, sh, lat_exp, lat, we0;

        err = (sz == 2'b11);
        aa  = a;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) err = 1'b1;
`else
        if (sz == 2'b01) aa[0]   = 1'b0;
        if (sz == 2'b10) aa[1:0] = 2'b00;
`endif
        idx  = int'((aa / 4) % MEM_WORDS);
        sh   = int'(aa % 4) * 8;
        w    = ref_mem[idx];
        v    = w >> sh;
        expd = 32'd0;
        if (!err && !wr) begin
            if (sz == 2'b00)      expd = un ? (v & 32'hFF)   : ((v & 32'h80)   != 0 ? (v | 32'hFFFF_FF00) : (v & 32'hFF));
            else if (sz == 2'b01) expd = un ? (v & 32'hFFFF) : ((v & 32'h8000) != 0 ? (v | 32'hFFFF_0000) : (v & 32'hFFFF));
            else                  expd = w;
        end
        mask    = (sz == 2'b00) ? (32'hFF << sh) : (sz == 2'b01) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
        merged  = (w & ~mask) | ((wd << sh) & mask);
        lat_exp = err ? 1 : (!wr ? 2 : (sz == 2'b10 ? 2 : 3));

        wait_ready();
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = un;
        req_addr     = a;
        req_wdata    = wd;
        we0          = we_cnt;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = 2'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;

        check("busy_ready", {31'd0, req_ready}, 32'd0);
        check("mem_addr", mem_addr, idx);
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, lat_exp);
        check("resp_err", {31'd0, resp_err}, {31'd0, err});
        check("resp_rdata", resp_rdata, expd);
        rd = resp_rdata;
        check("we_count", we_cnt - we0, (err || !wr) ? 0 : 1);
        if (!err && wr) begin
            check("we_addr", we_addr, idx);
            check("we_data", we_data, merged);
            ref_mem[idx] = merged;
        end
        @(posedge clk); #1;
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        check("ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        int          n0, t, we0, rc0;

        for (int i = 0; i < MEM_WORDS; i++) begin
            dmem[i]    = $urandom;
            ref_mem[i] = dmem[i];
        end
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_ready_in_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", {31'd0, req_ready}, 32'd1);

        // Word store then load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, r);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);
        check("lw_const", r, 32'hDEAD_BEEF);

        // Byte read-modify-write
        dmem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AB, r);
        check("sb_word", dmem[4], 32'h11AB_3344);

        // Sign / zero extension
        dmem[5] = 32'h0000_F080; ref_mem[5] = 32'h0000_F080;
        do_req(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, r); check("lb_const", r, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, r); check("lbu_const", r, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, r); check("lh_const", r, 32'hFFFF_F080);
        do_req(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, r); check("lhu_const", r, 32'h0000_F080);

        // Errors and misalignment
        do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678, r);
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, r);
        do_req(1'b1, 2'b01, 1'b0, 32'h35, 32'h0000_BEEF, r);

        // Address wrap
        do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, r);

        // Reset in the middle of a read-modify-write
        dmem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        wait_ready();
        we0 = we_cnt; rc0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h12; req_wdata = 32'h0000_00CD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rstmid_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_no_we", we_cnt - we0, 32'd0);
        check("rstmid_no_resp", resp_cnt - rc0, 32'd0);
        check("rstmid_word", dmem[4], ref_mem[4]);

        // Back-to-back accepts with req_valid held high
        wait_ready();
        n0 = acc_cyc.size();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0;
        t = 0;
        while (acc_cyc.size() < n0 + 3 && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        req_valid = 1'b0;
        check("hs_accepts", acc_cyc.size() - n0, 32'd3);
        if (acc_cyc.size() >= n0 + 3) begin
            check("hs_gap1", acc_cyc[n0+1] - acc_cyc[n0], 32'd3);
            check("hs_gap2", acc_cyc[n0+2] - acc_cyc[n0+1], 32'd3);
        end
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic
        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'h0000_003F;
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, r);
        end

        for (int i = 0; i < MEM_WORDS; i += 9)
            check("final_mem", dmem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
